// File: rtl/ita_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ita_pkg
// Description : Shared constants, element type and saturating add used by the
//               ITA datapath stages.
// Revision    : 1.0 - initial release
// ============================================================================
package ita_pkg;

    localparam int ACT_BITS     = 8;
    localparam int EXPAND_DIM   = 128;
    localparam int CONTRACT_DIM = 64;

    typedef logic [ACT_BITS-1:0] act_t;

    // The sum is formed one bit wider so that the carry-out selects the clamp.
    function automatic act_t sat_add_u(input act_t a, input act_t b);
        logic [ACT_BITS:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[ACT_BITS] ? {ACT_BITS{1'b1}} : w_sum[ACT_BITS-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ostream_bank.sv
`default_nettype none
// ============================================================================
// Module      : ostream_bank
// Description : One DIM x ACT_BITS vector register bank, parallel write and
//               indexed combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module ostream_bank
    import ita_pkg::*;
#(
    parameter int DIM      = 64,
    parameter int ACT_BITS = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [DIM-1:0][ACT_BITS-1:0]  wdata,
    input  logic [$clog2(DIM)-1:0]        raddr,
    output logic [ACT_BITS-1:0]           rdata
);

    // Storage is deliberately not reset; occupancy tracking makes stale data unreachable.
    logic [DIM-1:0][ACT_BITS-1:0] r_mem;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/contract_output_stream.sv
`default_nettype none
// ============================================================================
// Module      : contract_output_stream
// Description : Double-buffers contract-engine result vectors and streams them
//               out one element per valid/ready handshake, counting drops.
//               Build option: RESIDUAL_EN adds res_in with a saturating add.
// Revision    : 1.0 - initial release
// ============================================================================
module contract_output_stream
    import ita_pkg::*;
#(
    parameter int DIM      = CONTRACT_DIM,
    parameter int ACT_BITS = ita_pkg::ACT_BITS,
    parameter int CNT_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIM-1:0][ACT_BITS-1:0]  vec_in,
    input  logic                          vec_valid,
`ifdef RESIDUAL_EN
    input  logic [DIM-1:0][ACT_BITS-1:0]  res_in,
`endif
    output logic [ACT_BITS-1:0]           m_data,
    output logic [$clog2(DIM)-1:0]        m_index,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          drop_pulse,
    output logic [CNT_BITS-1:0]           drop_count
);

    localparam int IDX_W = $clog2(DIM);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DIM - 1);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [1:0]                   r_occ;
    logic [1:0]                   w_occ_nxt;
    logic                         r_wr_bank;
    logic                         r_rd_bank;
    logic [IDX_W-1:0]             r_index;
    logic                         r_drop_pulse;
    logic [CNT_BITS-1:0]          r_drop_count;
    logic                         w_xfer;
    logic                         w_final;
    logic                         w_accept;
    logic                         w_drop;
    logic [DIM-1:0][ACT_BITS-1:0] w_capture;
    logic [ACT_BITS-1:0]          w_rdata0;
    logic [ACT_BITS-1:0]          w_rdata1;

    assign w_xfer   = m_valid & m_ready;
    assign w_final  = w_xfer & (r_index == c_LAST_IDX);
    // A full buffer can still take a vector when the bank being read frees this cycle.
    assign w_accept = vec_valid & ((r_occ != c_OCC_FULL) | w_final);
    assign w_drop   = vec_valid & ~w_accept;

`ifdef RESIDUAL_EN
    for (genvar gi = 0; gi < DIM; gi++) begin : g_res_add
        assign w_capture[gi] = sat_add_u(vec_in[gi], res_in[gi]);
    end
`else
    assign w_capture = vec_in;
`endif

    ostream_bank #(.DIM(DIM), .ACT_BITS(ACT_BITS)) u_bank0 (
        .clk   (clk),
        .we    (w_accept & ~r_wr_bank),
        .wdata (w_capture),
        .raddr (r_index),
        .rdata (w_rdata0)
    );

    ostream_bank #(.DIM(DIM), .ACT_BITS(ACT_BITS)) u_bank1 (
        .clk   (clk),
        .we    (w_accept & r_wr_bank),
        .wdata (w_capture),
        .raddr (r_index),
        .rdata (w_rdata1)
    );

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= c_OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            c_OCC_EMPTY: if (w_accept)              w_occ_nxt = c_OCC_ONE;
            c_OCC_ONE:   if (w_accept & ~w_final)   w_occ_nxt = c_OCC_FULL;
                         else if (~w_accept & w_final) w_occ_nxt = c_OCC_EMPTY;
            c_OCC_FULL:  if (w_final & ~w_accept)   w_occ_nxt = c_OCC_ONE;
            default:                                w_occ_nxt = c_OCC_EMPTY;
        endcase
    end

    always_comb begin
        m_valid = (r_occ != c_OCC_EMPTY);
        busy    = (r_occ != c_OCC_EMPTY);
        m_last  = m_valid & (r_index == c_LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_index      <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_accept) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_final) begin
                r_rd_bank <= ~r_rd_bank;
                r_index   <= '0;
            end else if (w_xfer) begin
                r_index <= r_index + IDX_W'(1);
            end
            if (w_drop && (r_drop_count != {CNT_BITS{1'b1}})) begin
                r_drop_count <= r_drop_count + CNT_BITS'(1);
            end
        end
    end

    assign m_index    = r_index;
    assign m_data     = r_rd_bank ? w_rdata1 : w_rdata0;
    assign drop_pulse = r_drop_pulse;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_contract_output_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_contract_output_stream
// Description : Self-checking bench for contract_output_stream against a
//               queue-based reference model. Honours RESIDUAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contract_output_stream;

    localparam int DIM      = 64;
    localparam int CNT_BITS = 16;

    typedef logic [DIM-1:0][7:0] pvec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    pvec_t               vec_in = '0;
    pvec_t               res_in = '0;
    logic                vec_valid = 1'b0;
    logic                m_ready = 1'b0;
    logic [7:0]          m_data;
    logic [5:0]          m_index;
    logic                m_valid;
    logic                m_last;
    logic                busy;
    logic                drop_pulse;
    logic [CNT_BITS-1:0] drop_count;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of buffered vectors, read position, drop state.
    pvec_t q[$];
    int    idx = 0;
    int    drops = 0;
    bit    exp_dp = 1'b0;

    always #5 clk = ~clk;

    contract_output_stream #(.DIM(DIM), .ACT_BITS(8), .CNT_BITS(CNT_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vec_in     (vec_in),
        .vec_valid  (vec_valid),
`ifdef RESIDUAL_EN
        .res_in     (res_in),
`endif
        .m_data     (m_data),
        .m_index    (m_index),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pvec_t fill(input int val);
        pvec_t v;
        for (int i = 0; i < DIM; i++) v[i] = 8'(val);
        return v;
    endfunction

    function automatic pvec_t ramp();
        pvec_t v;
        for (int i = 0; i < DIM; i++) v[i] = 8'(i);
        return v;
    endfunction

    function automatic pvec_t rnd();
        pvec_t v;
        for (int i = 0; i < DIM; i++) v[i] = 8'($urandom);
        return v;
    endfunction

    function automatic pvec_t stored(input pvec_t v, input pvec_t r);
        pvec_t s;
        for (int i = 0; i < DIM; i++) begin
`ifdef RESIDUAL_EN
            int sum;
            sum = int'(v[i]) + int'(r[i]);
            s[i] = (sum > 255) ? 8'd255 : 8'(sum);
`else
            s[i] = v[i];
`endif
        end
        return s;
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, advance model, cross the edge.
    task automatic step(input bit vv, input pvec_t v, input pvec_t r, input bit rdy);
        bit ev, xfer, fin, acc;
        vec_valid = vv;
        vec_in    = v;
        res_in    = r;
        m_ready   = rdy;
        #3;
        ev = (q.size() != 0);
        check("m_valid", {31'd0, m_valid}, {31'd0, ev});
        check("busy", {31'd0, busy}, {31'd0, ev});
        if (ev) begin
            check("m_index", {26'd0, m_index}, idx);
            check("m_data", {24'd0, m_data}, {24'd0, q[0][idx]});
            check("m_last", {31'd0, m_last}, {31'd0, (idx == DIM - 1)});
        end else begin
            check("m_last_idle", {31'd0, m_last}, 32'd0);
        end
        check("drop_pulse", {31'd0, drop_pulse}, {31'd0, exp_dp});
        check("drop_count", {16'd0, drop_count}, drops);

        xfer = ev && rdy;
        fin  = xfer && (idx == DIM - 1);
        acc  = vv && ((q.size() < 2) || fin);
        if (fin) begin
            void'(q.pop_front());
            idx = 0;
        end else if (xfer) begin
            idx++;
        end
        if (acc) q.push_back(stored(v, r));
        exp_dp = vv && !acc;
        if (exp_dp && drops < (1 << CNT_BITS) - 1) drops++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, rdy);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        vec_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_m_index", {26'd0, m_index}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        q.delete();
        idx = 0;
        drops = 0;
        exp_dp = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pending;
        @(posedge clk);
        #1;
        do_reset();

        // Ramp vector streamed at full rate.
        step(1'b1, ramp(), '0, 1'b1);
        idle(70, 1'b1);

        // Two buffered while stalled, third dropped, then drain in order.
        step(1'b1, fill(8'h11), '0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, fill(8'h22), '0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, fill(8'h33), '0, 1'b0);
        idle(3, 1'b0);
        idle(140, 1'b1);

        // Capture coincident with the final handshake while full: no drop.
        step(1'b1, fill(8'h44), '0, 1'b0);
        step(1'b1, fill(8'h55), '0, 1'b0);
        pending = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (pending && q.size() == 2 && idx == DIM - 1) begin
                step(1'b1, fill(8'h66), '0, 1'b1);
                pending = 1'b0;
            end else begin
                step(1'b0, '0, '0, 1'b1);
            end
        end
        check("coincident_capture_seen", {31'd0, pending}, 32'd0);

        // Alternating backpressure across a whole vector.
        step(1'b1, rnd(), '0, 1'b0);
        for (int k = 0; k < 140; k++) step(1'b0, '0, '0, (k % 2) == 0);

        // Randomized traffic with drops.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 39) == 0, rnd(), rnd(), $urandom_range(0, 9) < 7);
        end
        idle(200, 1'b1);

`ifdef RESIDUAL_EN
        step(1'b1, fill(200), fill(100), 1'b1);
        idle(70, 1'b1);
        step(1'b1, fill(10), fill(5), 1'b1);
        idle(70, 1'b1);
`endif

        // Reset at beat 30, then a fresh vector streams from index 0.
        step(1'b1, rnd(), '0, 1'b1);
        for (int k = 0; k < 100 && idx != 30; k++) step(1'b0, '0, '0, 1'b1);
        check("reached_beat30", idx, 30);
        do_reset();
        idle(3, 1'b1);
        step(1'b1, ramp(), '0, 1'b1);
        idle(70, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/contract_output_stream.md
Name: contract_output_stream

Overview:
- Sits directly downstream of the contract engine (128->64 projection).
- Captures each 64-element, 8-bit result vector on the engine's one-cycle output_valid pulse into a two-bank buffer.
- Streams the buffered vectors out one element per handshake over a valid/ready interface.
- Absorbs the engine's lack of backpressure and counts vectors it must drop.

Parameters:
- DIM, 64, elements per vector (matches contract OUTPUT_DIM).
- ACT_BITS, 8, element width, unsigned.
- CNT_BITS, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- vec_in  in  ACT_BITS x DIM  parallel vector from the contract stage.
- vec_valid  in  1  one-cycle capture strobe.
- res_in  in  ACT_BITS x DIM  residual vector, sampled with vec_valid (present only with RESIDUAL_EN).
- m_data  out  ACT_BITS  current element.
- m_index  out  clog2(DIM)  index of the current element.
- m_valid  out  1  element available.
- m_ready  in  1  consumer accepts.
- m_last  out  1  current element is index DIM-1.
- busy  out  1  at least one bank occupied.
- drop_pulse  out  1  one-cycle pulse when a vector is discarded.
- drop_count  out  CNT_BITS  saturating count of discarded vectors.

Behaviour:
- Reset values (asynchronous): m_valid=0, m_last=0, m_index=0, busy=0, drop_pulse=0, drop_count=0, occupancy=0, wr_bank=0, rd_bank=0.
- Reset clears pointers and occupancy only; bank contents are not cleared.
- Reset mid-stream abandons the partial vector; the first m_valid after reset belongs to the next captured vector.
- Occupancy states: EMPTY (0), ONE (1), FULL (2).
- Capture: when vec_valid=1 and the vector is accepted, vec_in is written to bank[wr_bank] at the clock edge; wr_bank toggles and occupancy increments.
- Accept rule: a vector is accepted if occupancy < 2, OR occupancy == 2 and the final-element handshake (m_valid & m_ready & m_last) completes in the same cycle.
  - In the second case, the freed bank is rd_bank == wr_bank and occupancy stays 2.
- Drop: if vec_valid=1 and the vector is not accepted:
  - the vector is discarded;
  - drop_pulse=1 in the next cycle;
  - drop_count increments, saturating at 2^CNT_BITS-1.
- Stream outputs:
  - m_valid = (occupancy != 0).
  - m_data = bank[rd_bank][m_index], read combinationally from registered storage.
  - m_last = m_valid & (m_index == DIM-1).
- Latency: the first element is valid the cycle after the capture edge (one-cycle capture-to-m_valid).
- Transfer: on m_valid & m_ready, m_index increments.
  - At DIM-1, m_index wraps to 0, rd_bank toggles and occupancy decrements (unless a simultaneous capture holds it).
- While m_ready=0, m_data and m_index are held stable.
- Simultaneous capture with occupancy==1 and a non-final transfer: capture goes to the other bank and occupancy becomes 2.
- Simultaneous capture and final-element release with occupancy==1: occupancy stays 1 and the stream continues seamlessly into the new bank.
- busy = (occupancy != 0).
- Throughput: full rate is 1 element per cycle, i.e. DIM cycles per vector. The contract engine emits at most once per INPUT_DIM+2 cycles (130), so with m_ready held high drops never occur.

Optional Feature:
- Macro: RESIDUAL_EN.
- Defined: res_in port exists.
  - Stored element = min(vec_in[i] + res_in[i], 2^ACT_BITS-1), an unsigned saturating add computed at ACT_BITS+1 width.
  - res_in is sampled only on accepted captures.
- Undefined: res_in port is absent and the stored element = vec_in[i] unchanged.

Decomposition:
- Shared package ita_pkg holds:
  - constants ACT_BITS=8, EXPAND_DIM=128, CONTRACT_DIM=64;
  - typedef act_t (logic [ACT_BITS-1:0]);
  - function sat_add_u (saturating unsigned add), shared with other stages.
- One sub-module, ostream_bank: a single DIM x ACT_BITS register bank with write-enable and indexed read port, instantiated twice.
- Occupancy, handshake and drop logic stay in the top module.

Test Plan:
- Reset, then capture vec_in[i]=i with m_ready=1 -> m_valid rises the cycle after capture; 64 beats with m_data=0..63 and m_index=0..63; m_last only on beat 63; busy falls after beat 63.
- m_ready=0, capture vectors A (all 0x11) and B (all 0x22), then a third C -> C dropped, drop_pulse one cycle, drop_count=1; releasing m_ready streams 64x 0x11 then 64x 0x22.
- Occupancy 2 with m_ready=1: assert vec_valid exactly on the m_last handshake of A -> no drop, drop_count unchanged; stream sequence is B then the new vector.
- m_ready toggled 1/0 every cycle across a vector -> m_data/m_index stable while stalled; exactly 64 transfers with no skipped or repeated indices.
- RESIDUAL_EN defined: vec_in=200, res_in=100 for all i -> all outputs 255; vec_in=10, res_in=5 -> all outputs 15.
- Assert rst_n low at beat 30 of a stream -> all outputs return to reset values immediately; the next capture streams from m_index 0.
